// File: rtl/alu4_issue_ctl.sv
// Issue/writeback controller for the combinational alu4: IDLE -> EXEC -> WB per instruction.
// Define ALU4_ISSUE_BYPASS_EN to accept in WB and forward the pending result to operands.
module alu4_issue_ctl #(
  parameter int unsigned NREG = 4,
  parameter int unsigned DW   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_op,
  input  logic [$clog2(NREG)-1:0] in_rd,
  input  logic [$clog2(NREG)-1:0] in_rs,
  input  logic [$clog2(NREG)-1:0] in_rt,
  input  logic                    ld_en,
  input  logic [$clog2(NREG)-1:0] ld_addr,
  input  logic [DW-1:0]           ld_data,
  output logic [1:0]              alu_ctl,
  output logic [DW-1:0]           alu_a,
  output logic [DW-1:0]           alu_b,
  input  logic [DW-1:0]           alu_out,
  input  logic                    alu_zf,
  input  logic                    alu_cf,
  input  logic                    alu_sf,
  output logic                    done,
  output logic [DW-1:0]           wb_data,
  output logic [2:0]              flags,
  output logic [DW-1:0]           rd_data0,
  output logic [DW-1:0]           rd_data1,
  output logic [DW-1:0]           rd_data2,
  output logic [DW-1:0]           rd_data3
);

  localparam int unsigned AW = $clog2(NREG);

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] regs_q [NREG];
  logic [AW-1:0] rd_q;
  logic [1:0]    alu_ctl_q;
  logic [DW-1:0] alu_a_q, alu_b_q;
  logic [DW-1:0] res_q;
  logic [2:0]    fl_q, flags_q;
  logic [DW-1:0] opa, opb;
  logic          accept;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StExec;
      end
      StExec: state_d = StWb;
      StWb: begin
        done    = 1'b1;
`ifdef ALU4_ISSUE_BYPASS_EN
        in_ready = 1'b1;
        state_d  = in_valid ? StExec : StIdle;
`else
        state_d  = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  assign accept = in_valid & in_ready;

  // Operands come from pre-edge register state; bypass covers the result retiring this edge.
  always_comb begin
    opa = regs_q[in_rs];
    opb = regs_q[in_rt];
`ifdef ALU4_ISSUE_BYPASS_EN
    if (state_q == StWb && in_rs == rd_q) opa = res_q;
    if (state_q == StWb && in_rt == rd_q) opb = res_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rd_q      <= '0;
      alu_ctl_q <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      res_q     <= '0;
      fl_q      <= '0;
      flags_q   <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_ctl_q <= in_op;
        alu_a_q   <= opa;
        alu_b_q   <= opb;
        rd_q      <= in_rd;
      end
      if (state_q == StExec) begin
        res_q <= alu_out;
        fl_q  <= {alu_sf, alu_cf, alu_zf};
      end
      if (ld_en) regs_q[ld_addr] <= ld_data;
      // Placed after the host load so writeback wins on an address clash.
      if (state_q == StWb) begin
        regs_q[rd_q] <= res_q;
        flags_q      <= fl_q;
      end
    end
  end

  assign alu_ctl  = alu_ctl_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign wb_data  = res_q;
  assign flags    = flags_q;
  assign rd_data0 = regs_q[0];
  assign rd_data1 = regs_q[1];
  assign rd_data2 = regs_q[2];
  assign rd_data3 = regs_q[3];

endmodule

// File: tb/tb_alu4_issue_ctl.sv
// Directed bench for alu4_issue_ctl with a behavioural alu4 (CF reports signed overflow).
// Expected accept spacing follows ALU4_ISSUE_BYPASS_EN when the bench is built with it.
module tb_alu4_issue_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op, in_rd, in_rs, in_rt;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [3:0] ld_data;
  logic [1:0] alu_ctl;
  logic [3:0] alu_a, alu_b, alu_out;
  logic       alu_zf, alu_cf, alu_sf;
  logic       done;
  logic [3:0] wb_data;
  logic [2:0] flags;
  logic [3:0] rd_data0, rd_data1, rd_data2, rd_data3;

  int checks = 0;
  int errors = 0;

`ifdef ALU4_ISSUE_BYPASS_EN
  localparam int Gap = 2;
  localparam logic WbReady = 1'b1;
`else
  localparam int Gap = 3;
  localparam logic WbReady = 1'b0;
`endif

  always #5 clk = ~clk;

  alu4_issue_ctl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_sf(alu_sf), .done(done), .wb_data(wb_data),
    .flags(flags), .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_data3(rd_data3)
  );

  // alu4 stand-in
  always_comb begin
    alu_out = '0;
    alu_cf  = 1'b0;
    case (alu_ctl)
      2'd0: alu_out = alu_a & alu_b;
      2'd1: alu_out = alu_a | alu_b;
      2'd2: begin
        alu_out = alu_a + alu_b;
        alu_cf  = (alu_a[3] == alu_b[3]) && (alu_out[3] != alu_a[3]);
      end
      default: begin
        alu_out = alu_a - alu_b;
        alu_cf  = (alu_a[3] != alu_b[3]) && (alu_out[3] != alu_a[3]);
      end
    endcase
    alu_zf = (alu_out == 4'd0);
    alu_sf = alu_out[3];
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] a, input logic [3:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [1:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [1:0] rt, input logic [3:0] ea,
                       input logic [3:0] eb, input logic [3:0] eres);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
    chk({tag, "_ready_idle"}, {7'd0, in_ready}, 8'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_ctl"}, {6'd0, alu_ctl}, {6'd0, op});
    chk({tag, "_a"}, {4'd0, alu_a}, {4'd0, ea});
    chk({tag, "_b"}, {4'd0, alu_b}, {4'd0, eb});
    chk({tag, "_exec_busy"}, {6'd0, in_ready, done}, 8'd0);
    tick();
    chk({tag, "_done"}, {7'd0, done}, 8'd1);
    chk({tag, "_wb_data"}, {4'd0, wb_data}, {4'd0, eres});
  endtask

  initial begin
    int acc [3];
    int n;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", {7'd0, in_ready}, 8'd1);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_regs", {rd_data0, rd_data1} | {rd_data2, rd_data3}, 8'd0);
    chk("rst_alu", {alu_ctl, alu_a[1:0]} | {alu_a[3:2], alu_b}, 8'd0);
    chk("rst_flags_wb", {1'b0, flags, wb_data}, 8'd0);

    // 1: ADD 3+4
    load(2'd1, 4'd3); load(2'd2, 4'd4);
    issue("add", 2'd2, 2'd0, 2'd1, 2'd2, 4'd3, 4'd4, 4'd7);
    tick();
    chk("add_r0", {4'd0, rd_data0}, 8'd7);
    chk("add_flags", {5'd0, flags}, 8'b000);
    chk("add_done_clr", {7'd0, done}, 8'd0);

    // 2: SUB 5-5 -> zero
    load(2'd1, 4'd5); load(2'd2, 4'd5);
    issue("sub", 2'd3, 2'd3, 2'd1, 2'd2, 4'd5, 4'd5, 4'd0);
    tick();
    chk("sub_r3", {4'd0, rd_data3}, 8'd0);
    chk("sub_flags", {5'd0, flags}, 8'b001);

    // 3: 7+1 overflows, rd==rs
    load(2'd1, 4'd7); load(2'd2, 4'd1);
    issue("ovf", 2'd2, 2'd1, 2'd1, 2'd2, 4'd7, 4'd1, 4'd8);
    chk("ovf_flags_hold", {5'd0, flags}, 8'b001);
    tick();
    chk("ovf_r1", {4'd0, rd_data1}, 8'd8);
    chk("ovf_flags", {5'd0, flags}, 8'b110);

    // 4: in_valid held for three ORs (R1=8, R2=1)
    in_valid = 1'b1; in_op = 2'd1; in_rd = 2'd3; in_rs = 2'd1; in_rt = 2'd2;
    n = 0;
    for (int cyc = 0; cyc < 12 && n < 3; cyc++) begin
      if (cyc == 1) chk("stream_exec_ready", {7'd0, in_ready}, 8'd0);
      if (cyc == 2) chk("stream_wb_ready", {7'd0, in_ready}, {7'd0, WbReady});
      if (in_ready) begin
        acc[n] = cyc;
        n++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("stream_count", n[7:0], 8'd3);
    chk("stream_gap01", 8'(acc[1] - acc[0]), 8'(Gap));
    chk("stream_gap12", 8'(acc[2] - acc[1]), 8'(Gap));
    tick(); tick();
    chk("stream_r3", {4'd0, rd_data3}, 8'd9);

    // 4b: dependent chain R0=R1+R2 (9), R3=R0|R0
    in_valid = 1'b1; in_op = 2'd2; in_rd = 2'd0; in_rs = 2'd1; in_rt = 2'd2;
    tick();
    in_op = 2'd1; in_rd = 2'd3; in_rs = 2'd0; in_rt = 2'd0;
    n = 0;
    while (!in_ready && n < 5) begin
      tick();
      n++;
    end
    chk("chain_wait", n[7:0], 8'(Gap - 1));
    tick();
    in_valid = 1'b0;
    chk("chain_fwd_a", {4'd0, alu_a}, 8'd9);
    chk("chain_fwd_b", {4'd0, alu_b}, 8'd9);
    chk("chain_op", {6'd0, alu_ctl}, 8'd1);
    tick(); tick();
    chk("chain_r0", {4'd0, rd_data0}, 8'd9);
    chk("chain_r3", {4'd0, rd_data3}, 8'd9);

    // 5: host load clashing with writeback
    load(2'd1, 4'd3);
    issue("clash", 2'd2, 2'd2, 2'd1, 2'd1, 4'd3, 4'd3, 4'd6);
    ld_en = 1'b1; ld_addr = 2'd2; ld_data = 4'd9;
    tick();
    ld_en = 1'b0;
    chk("clash_r2", {4'd0, rd_data2}, 8'd6);
    load(2'd2, 4'd0);
    issue("both", 2'd2, 2'd2, 2'd1, 2'd1, 4'd3, 4'd3, 4'd6);
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 4'd9;
    tick();
    ld_en = 1'b0;
    chk("both_r2", {4'd0, rd_data2}, 8'd6);
    chk("both_r1", {4'd0, rd_data1}, 8'd9);

    // 6: reset during EXEC
    issue("pre_rst", 2'd3, 2'd3, 2'd1, 2'd1, 4'd9, 4'd9, 4'd0);
    tick();
    chk("pre_rst_flags", {5'd0, flags}, 8'b001);
    in_valid = 1'b1; in_op = 2'd2; in_rd = 2'd0; in_rs = 2'd1; in_rt = 2'd1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", {7'd0, in_ready}, 8'd1);
    chk("mid_rst_done", {7'd0, done}, 8'd0);
    chk("mid_rst_regs", {rd_data0, rd_data1} | {rd_data2, rd_data3}, 8'd0);
    chk("mid_rst_flags", {5'd0, flags}, 8'd0);
    tick();
    chk("mid_rst_no_wb", {3'd0, done, rd_data0}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu4_issue_ctl.md
Name: alu4_issue_ctl

Overview:
- Upstream issue/writeback stage for the 4-bit ALU (alu4).
- Accepts ALU instructions over a valid/ready handshake and reads operands from an internal 4x4-bit register file.
- Drives ALUctl/A/B to alu4, captures ALUOut and ZF/CF/SF, then writes the result back to the register file and a flags register.
- A host load port preloads registers; the ALU itself stays purely combinational.

Parameters:
NREG, 4, number of registers (fixed at 4; address width 2)
DW, 4, data width; must match alu4 operand width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  instruction valid
in_ready  output  1  block can accept instruction this cycle
in_op  input  2  ALU op: 0 AND, 1 OR, 2 signed ADD, 3 signed SUB
in_rd  input  2  destination register
in_rs  input  2  source A register
in_rt  input  2  source B register
ld_en  input  1  host register load strobe
ld_addr  input  2  host load register index
ld_data  input  4  host load data
alu_ctl  output  2  to alu4 ALUctl (registered)
alu_a  output  4  to alu4 A (registered)
alu_b  output  4  to alu4 B (registered)
alu_out  input  4  from alu4 ALUOut
alu_zf  input  1  from alu4 ZF
alu_cf  input  1  from alu4 CF
alu_sf  input  1  from alu4 SF
done  output  1  high for exactly the WB cycle of each instruction
wb_data  output  4  result being written back (valid when done)
flags  output  3  {SF,CF,ZF} of last completed instruction
rd_data0..rd_data3  output  4 each  register file contents (debug/observe)

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; all registers R0..R3=0; flags=3'b000; alu_ctl=0, alu_a=0, alu_b=0; wb_data=0; done=0; in_ready=1 the cycle after reset.
  - Reset mid-instruction abandons it: no writeback, no done.
- FSM states IDLE, EXEC, WB.
  - IDLE: in_ready=1. On in_valid&in_ready, latch op/rd into an instruction register; alu_ctl<=in_op, alu_a<=R[in_rs], alu_b<=R[in_rt]. Go to EXEC.
  - EXEC: in_ready=0; alu4 outputs settle. At the edge, capture res<=alu_out and fl<={alu_sf,alu_cf,alu_zf}. Go to WB.
  - WB: done=1, wb_data=res, in_ready=0 (see Optional Feature). At the edge, R[rd]<=res and flags<=fl. Go to IDLE.
- Latency: accept edge to done = 2 cycles. Throughput: 1 instruction per 3 cycles.
- Operands are read from register state before the accept edge. A ld_en to the same register in the accept cycle is not seen; the old value is used.
- ld_en is honoured in any state: R[ld_addr]<=ld_data.
- Same-cycle conflict in WB with ld_addr==rd: writeback wins. Different addresses: both writes happen.
- rd==rs or rd==rt is legal; operands were already captured.
- alu_ctl/alu_a/alu_b hold their value outside EXEC. They change only on accept.
- Flags are updated only at the WB edge. ld_en never touches flags.
- No arithmetic in this block; width/sign semantics belong to alu4.

Optional Feature:
- Macro: ALU4_ISSUE_BYPASS_EN.
- Defined:
  - in_ready=1 also in WB. An instruction accepted in WB goes directly to EXEC, giving 1 instruction per 2 cycles.
  - Operand read in that cycle forwards res instead of R[x] when in_rs or in_rt equals the WB rd.
  - Writeback and flags update still occur at the same edge.
- Undefined: in_ready=0 in WB and there is no forwarding path.

Test Plan:
1. Reset then ld R1=3, R2=4; issue ADD rd=0 rs=1 rt=2 -> alu_a=3, alu_b=4, alu_ctl=2 in EXEC; done with wb_data=7 two cycles after accept; R0=7; flags=000.
2. ld R1=5, R2=5; SUB rd=3 rs=1 rt=2 -> R3=0, flags ZF=1 (flags=001).
3. ld R1=4'b0111, R2=1; ADD rd=1 rs=1 rt=2 -> alu4 CF=1 and SF captured as driven; R1=4'b1000; rd==rs handled with old operand 7.
4. in_valid held high continuously, 3 instructions, macro undefined -> accepts spaced 3 cycles apart; in_ready low in EXEC and WB. Macro defined -> accepts 2 cycles apart; dependent chain ADD R0=R1+R2 then OR R3=R0|R0 forwards the fresh R0 value.
5. In the WB cycle of an instruction with rd=2, ld_en with ld_addr=2, ld_data=9 -> R2 holds the ALU result, not 9. Same test with ld_addr=1 -> both writes land.
6. Assert rst during EXEC -> no done, registers and flags return to 0, in_ready=1 on the next cycle.
